// File: rtl/md_fp_pkg.sv
`default_nettype none
// ============================================================================
// Package : md_fp_pkg
// Brief   : Shared fp32 field positions, component indices and sequencer types.
// Revision: 1.0  initial release
// ============================================================================
package md_fp_pkg;

    localparam int         FP32_W       = 32;
    localparam int         FP32_EXP_MSB = 30;
    localparam int         FP32_EXP_LSB = 23;
    localparam logic [7:0] FP32_EXP_INF = 8'hFF;

    localparam logic [1:0] X = 2'd0;
    localparam logic [1:0] Y = 2'd1;
    localparam logic [1:0] Z = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } sq_state_t;

    typedef struct packed {
        logic       v;
        logic [1:0] idx;
    } sq_tag_t;

    function automatic logic is_nonfinite(input logic [FP32_W-1:0] f);
        return f[FP32_EXP_MSB:FP32_EXP_LSB] == FP32_EXP_INF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lat_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module  : lat_tag_pipe
// Brief   : Delays {valid, idx} tags by DEPTH cycles to line up with products.
// Revision: 1.0  initial release
// ============================================================================
module lat_tag_pipe
    import md_fp_pkg::*;
#(
    parameter int DEPTH = 0
) (
    input  logic    clk,
    input  logic    rst,
    input  sq_tag_t tag_in,
    output sq_tag_t tag_out
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Combinational multiplier: the tag meets its product in the same cycle.
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ rst;
            assign tag_out          = tag_in;
        end else begin : g_pipe
            sq_tag_t r_stage [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= tag_in;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign tag_out = r_stage[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fp32_sq_issue.sv
`default_nettype none
// ============================================================================
// Module  : fp32_sq_issue
// Brief   : Issues dx*dx, dy*dy, dz*dz to the shared fp32 multiplier and
//           presents the collected squares to the r^2 adder with valid/ready.
// Revision: 1.0  initial release
// ============================================================================
module fp32_sq_issue
    import md_fp_pkg::*;
#(
    parameter int MUL_LAT = 0,
    parameter int W       = FP32_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_dx,
    input  logic [W-1:0] in_dy,
    input  logic [W-1:0] in_dz,
    output logic [W-1:0] mul_a,
    output logic [W-1:0] mul_b,
    input  logic [W-1:0] mul_o,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sq_x,
    output logic [W-1:0] out_sq_y,
    output logic [W-1:0] out_sq_z,
    output logic         out_nonfinite
);

    sq_state_t    r_state;
    sq_state_t    w_state_nxt;
    logic [W-1:0] r_dx;
    logic [W-1:0] r_dy;
    logic [W-1:0] r_dz;
    logic [1:0]   r_idx;
    logic [W-1:0] r_sq_x;
    logic [W-1:0] r_sq_y;
    logic [W-1:0] r_sq_z;
    logic         r_nonfinite;

    logic [W-1:0] w_operand;
    logic [W-1:0] w_sq_x_nxt;
    logic [W-1:0] w_sq_y_nxt;
    logic [W-1:0] w_sq_z_nxt;
    logic         w_accept;
    sq_tag_t      w_tag_in;
    sq_tag_t      w_tag_out;

    assign in_ready = (r_state == IDLE) && !rst;
    assign w_accept = in_valid && in_ready;

    lat_tag_pipe #(
        .DEPTH (MUL_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (w_tag_in),
        .tag_out (w_tag_out)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = ISSUE;
            ISSUE:   if (r_idx == Z) w_state_nxt = (MUL_LAT == 0) ? HOLD : DRAIN;
            DRAIN:   if (w_tag_out.v && (w_tag_out.idx == Z)) w_state_nxt = HOLD;
            HOLD:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Squaring: both multiplier operands carry the same component.
    always_comb begin
        w_operand = '0;
        if (r_state == ISSUE) begin
            case (r_idx)
                X:       w_operand = r_dx;
                Y:       w_operand = r_dy;
                default: w_operand = r_dz;
            endcase
        end
        w_tag_in.v   = (r_state == ISSUE);
        w_tag_in.idx = r_idx;
    end

    assign mul_a = w_operand;
    assign mul_b = w_operand;

    always_comb begin
        w_sq_x_nxt = r_sq_x;
        w_sq_y_nxt = r_sq_y;
        w_sq_z_nxt = r_sq_z;
        if (w_tag_out.v) begin
            case (w_tag_out.idx)
                X:       w_sq_x_nxt = mul_o;
                Y:       w_sq_y_nxt = mul_o;
                Z:       w_sq_z_nxt = mul_o;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_dx        <= '0;
            r_dy        <= '0;
            r_dz        <= '0;
            r_idx       <= X;
            r_sq_x      <= '0;
            r_sq_y      <= '0;
            r_sq_z      <= '0;
            r_nonfinite <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_dx  <= in_dx;
                r_dy  <= in_dy;
                r_dz  <= in_dz;
                r_idx <= X;
            end else if (r_state == ISSUE) begin
                r_idx <= r_idx + 2'd1;
            end
            r_sq_x      <= w_sq_x_nxt;
            r_sq_y      <= w_sq_y_nxt;
            r_sq_z      <= w_sq_z_nxt;
            r_nonfinite <= is_nonfinite(w_sq_x_nxt) | is_nonfinite(w_sq_y_nxt) |
                           is_nonfinite(w_sq_z_nxt);
        end
    end

    assign out_valid     = (r_state == HOLD);
    assign out_sq_x      = r_sq_x;
    assign out_sq_y      = r_sq_y;
    assign out_sq_z      = r_sq_z;
    assign out_nonfinite = r_nonfinite;

endmodule
`default_nettype wire

// File: tb/tb_fp32_sq_issue.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp32_sq_issue
// Brief   : Directed bench for fp32_sq_issue at MUL_LAT = 0, 4 and 2.
// Revision: 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fp32_sq_issue;

    localparam int N = 3;
    // Accept-to-valid is 3+MUL_LAT edges, then one HOLD edge and one IDLE edge.
    localparam int C_T6_INTERVAL = 2 + 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [N];
    logic        in_valid  [N];
    logic        in_ready  [N];
    logic [31:0] dx        [N];
    logic [31:0] dy        [N];
    logic [31:0] dz        [N];
    logic [31:0] mul_a     [N];
    logic [31:0] mul_b     [N];
    logic [31:0] mul_o     [N];
    logic        out_valid [N];
    logic        out_ready [N];
    logic [31:0] sqx       [N];
    logic [31:0] sqy       [N];
    logic [31:0] sqz       [N];
    logic        nonf      [N];

    int tests = 0;
    int fails = 0;
    logic [31:0] hist [$];
    int ab_diff;

    // Stand-in multiplier: exact square for mantissas with 11 fraction bits.
    function automatic logic [31:0] fsq(input logic [31:0] a);
        logic [7:0]  e;
        logic [23:0] m;
        logic [23:0] p;
        int          eo;
        e = a[30:23];
        if (e == 8'hFF) return {1'b0, a[30:0]};
        if (e == 8'h00) return 32'h0;
        m  = {12'd0, 1'b1, a[22:12]};
        p  = m * m;
        eo = 2 * (int'(e) - 127) + 127;
        if (p[23]) return {1'b0, 8'(eo + 1), p[22:0]};
        return {1'b0, 8'(eo), p[21:0], 1'b0};
    endfunction

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            localparam int ML = (g == 0) ? 0 : ((g == 1) ? 4 : 2);
            fp32_sq_issue #(.MUL_LAT(ML), .W(32)) u_dut (
                .clk           (clk),
                .rst           (rst[g]),
                .in_valid      (in_valid[g]),
                .in_ready      (in_ready[g]),
                .in_dx         (dx[g]),
                .in_dy         (dy[g]),
                .in_dz         (dz[g]),
                .mul_a         (mul_a[g]),
                .mul_b         (mul_b[g]),
                .mul_o         (mul_o[g]),
                .out_valid     (out_valid[g]),
                .out_ready     (out_ready[g]),
                .out_sq_x      (sqx[g]),
                .out_sq_y      (sqy[g]),
                .out_sq_z      (sqz[g]),
                .out_nonfinite (nonf[g])
            );
            if (ML == 0) begin : g_comb
                assign mul_o[g] = fsq(mul_a[g]);
            end else begin : g_lat
                logic [31:0] dl [ML];
                always @(posedge clk) begin
                    dl[0] <= fsq(mul_a[g]);
                    for (int i = 1; i < ML; i++) dl[i] <= dl[i-1];
                end
                assign mul_o[g] = dl[ML-1];
            end
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input int k, input string tag, input logic [31:0] ex,
                           input logic [31:0] ey, input logic [31:0] ez, input logic enf);
        chk({tag, ".sq_x"}, sqx[k], ex);
        chk({tag, ".sq_y"}, sqy[k], ey);
        chk({tag, ".sq_z"}, sqz[k], ez);
        chk({tag, ".nonfinite"}, 32'(nonf[k]), 32'(enf));
    endtask

    task automatic chk_zero(input int k, input string tag);
        chk({tag, ".in_ready"}, 32'(in_ready[k]), 32'd0);
        chk({tag, ".out_valid"}, 32'(out_valid[k]), 32'd0);
        chk({tag, ".mul_a"}, mul_a[k], 32'd0);
        chk({tag, ".mul_b"}, mul_b[k], 32'd0);
        chk_out(k, tag, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic send(input int k, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] z);
        int n;
        n = 0;
        in_valid[k] = 1'b1;
        dx[k] = x;
        dy[k] = y;
        dz[k] = z;
        while (!in_ready[k] && n < 50) begin
            tick();
            n++;
        end
        chk("send.in_ready", 32'(in_ready[k]), 32'd1);
        tick();
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k, input string tag, input int exp_edges);
        int n;
        n = 0;
        ab_diff = 0;
        hist.delete();
        while (!out_valid[k] && n < 60) begin
            hist.push_back(mul_a[k]);
            if (mul_a[k] !== mul_b[k]) ab_diff++;
            tick();
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'(exp_edges));
        chk({tag, ".mul_a_eq_b"}, 32'(ab_diff), 32'd0);
    endtask

    task automatic release_hold(input int k);
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rx [20];
        logic [31:0] ry [20];
        logic [31:0] rz [20];
        int cyc, got, last, vi;
        logic acc;

        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
            dx[k] = 32'd0; dy[k] = 32'd0; dz[k] = 32'd0;
        end
        tick();
        tick();
        for (int k = 0; k < N; k++) chk_zero(k, "reset");
        for (int k = 0; k < N; k++) rst[k] = 1'b0;
        tick();

        // T1: combinational multiplier
        chk("t1.idle_ready", 32'(in_ready[0]), 32'd1);
        send(0, 32'h40400000, 32'hC0000000, 32'h3F000000);
        wait_valid(0, "t1", 3);
        chk("t1.mul_a0", hist[0], 32'h40400000);
        chk("t1.mul_a1", hist[1], 32'hC0000000);
        chk("t1.mul_a2", hist[2], 32'h3F000000);
        chk_out(0, "t1", 32'h41100000, 32'h40800000, 32'h3E800000, 1'b0);
        release_hold(0);
        chk("t1.valid_drop", 32'(out_valid[0]), 32'd0);
        chk("t1.ready_back", 32'(in_ready[0]), 32'd1);

        // T2: four-cycle multiplier
        send(1, 32'h40400000, 32'hC0000000, 32'h3F000000);
        wait_valid(1, "t2", 7);
        chk("t2.mul_a0", hist[0], 32'h40400000);
        chk("t2.mul_a1", hist[1], 32'hC0000000);
        chk("t2.mul_a2", hist[2], 32'h3F000000);
        chk("t2.mul_a3", hist[3], 32'h00000000);
        chk_out(1, "t2", 32'h41100000, 32'h40800000, 32'h3E800000, 1'b0);

        // T3: back-pressure in HOLD with a pending vector
        in_valid[1] = 1'b1;
        dx[1] = 32'h3F800000; dy[1] = 32'h3F800000; dz[1] = 32'h3F800000;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t3.hold_valid", 32'(out_valid[1]), 32'd1);
            chk("t3.hold_ready", 32'(in_ready[1]), 32'd0);
            chk_out(1, "t3.hold", 32'h41100000, 32'h40800000, 32'h3E800000, 1'b0);
        end
        release_hold(1);
        chk("t3.valid_drop", 32'(out_valid[1]), 32'd0);
        chk("t3.ready_back", 32'(in_ready[1]), 32'd1);
        tick();
        in_valid[1] = 1'b0;
        chk("t3.busy", 32'(in_ready[1]), 32'd0);
        wait_valid(1, "t3", 7);
        chk("t3.mul_a0", hist[0], 32'h3F800000);
        chk_out(1, "t3", 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0);
        release_hold(1);

        // T4: infinity flags nonfinite, next clean vector clears it
        send(0, 32'h40400000, 32'h7F800000, 32'h3F000000);
        wait_valid(0, "t4", 3);
        chk_out(0, "t4", 32'h41100000, 32'h7F800000, 32'h3E800000, 1'b1);
        release_hold(0);
        send(0, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        wait_valid(0, "t4c", 3);
        chk_out(0, "t4c", 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0);
        release_hold(0);

        // T5: reset mid-ISSUE; stale products still leave the multiplier afterwards
        send(1, 32'h40400000, 32'hC0000000, 32'h3F000000);
        tick();
        tick();
        rst[1] = 1'b1;
        #1;
        chk_zero(1, "t5.rst");
        tick();
        tick();
        rst[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t5.no_valid", 32'(out_valid[1]), 32'd0);
            chk("t5.no_stale_x", sqx[1], 32'd0);
            chk("t5.no_stale_y", sqy[1], 32'd0);
        end
        send(1, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        wait_valid(1, "t5", 7);
        chk_out(1, "t5", 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0);
        release_hold(1);

        // T6: back-to-back random vectors, out_ready held high
        for (int i = 0; i < 20; i++) begin
            rx[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 11'($urandom), 12'd0};
            ry[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 11'($urandom), 12'd0};
            rz[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 11'($urandom), 12'd0};
        end
        out_ready[2] = 1'b1;
        vi = 0;
        dx[2] = rx[0]; dy[2] = ry[0]; dz[2] = rz[0];
        in_valid[2] = 1'b1;
        cyc = 0; got = 0; last = 0;
        while (got < 20 && cyc < 400) begin
            if (out_valid[2]) begin
                chk_out(2, "t6", fsq(rx[got]), fsq(ry[got]), fsq(rz[got]), 1'b0);
                if (got > 0) chk("t6.interval", 32'(cyc - last), 32'(C_T6_INTERVAL));
                last = cyc;
                got++;
            end
            acc = in_valid[2] && in_ready[2];
            tick();
            cyc++;
            if (acc) begin
                vi++;
                if (vi < 20) begin
                    dx[2] = rx[vi]; dy[2] = ry[vi]; dz[2] = rz[vi];
                end else begin
                    in_valid[2] = 1'b0;
                end
            end
        end
        chk("t6.count", 32'(got), 32'd20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
